// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared definitions for the PISO serializer: state encoding,
//               default word width and a constant clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    localparam int c_DATA_WIDTH_DEFAULT = 8;

    // Two-state FSM encoding
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    // Ceiling log2, used to size the bit counter at elaboration time
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_reg
// Description : Loadable shift register with selectable shift direction.
//               The head bit is the flop that is shifted out next; the
//               vacated end fills with zeros so an emptied register reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_head
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign w_next = {1'b0, r_q[WIDTH-1:1]};
            assign o_head = r_q[0];
        end else begin : g_msb
            assign w_next = {r_q[WIDTH-2:0], 1'b0};
            assign o_head = r_q[WIDTH-1];
        end
    endgenerate

    // Load takes priority over shift so a back-to-back word replaces the tail
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in/serial-out transmitter with valid/ready input
//               handshake and zero-gap back-to-back words.
//               Optional macro PISO_PARITY_EN appends an even-parity bit
//               after the data bits of every word.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT,
    parameter int LSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  sout,
    output logic                  sout_valid,
    output logic                  frame_start,
    output logic                  done_tick,
    output logic                  busy
);

    localparam int c_CNT_W = clog2(DATA_WIDTH + 2);
`ifdef PISO_PARITY_EN
    localparam int c_N = DATA_WIDTH + 1;
`else
    localparam int c_N = DATA_WIDTH;
`endif
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_frame_start;
    logic               r_done_tick;
    logic               w_last;
    logic               w_accept;
    logic               w_shift;
    logic [c_N-1:0]     w_load_word;

    assign w_last    = (r_state == c_ST_SHIFT) && (r_cnt == c_LAST);
    assign din_ready = (r_state == c_ST_IDLE) || w_last;
    assign w_accept  = din_valid && din_ready;
    assign w_shift   = (r_state == c_ST_SHIFT) && !w_accept;

`ifdef PISO_PARITY_EN
    // The parity bit is captured at accept time as the tail of the shift word
    logic w_parity;
    assign w_parity = ^din;
    generate
        if (LSB_FIRST != 0) begin : g_par_lsb
            assign w_load_word = {w_parity, din};
        end else begin : g_par_msb
            assign w_load_word = {din, w_parity};
        end
    endgenerate
`else
    assign w_load_word = din;
`endif

    piso_shift_reg #(
        .WIDTH     (c_N),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift_reg (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (w_load_word),
        .o_head  (sout)
    );

    // FSM, bit counter and registered frame markers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
            r_done_tick   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt         <= '0;
                    r_done_tick   <= 1'b0;
                    r_frame_start <= w_accept;
                    if (w_accept) begin
                        r_state <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_last) begin
                        r_cnt         <= '0;
                        r_done_tick   <= 1'b0;
                        r_frame_start <= w_accept;
                        if (!w_accept) begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_cnt         <= r_cnt + c_CNT_W'(1);
                        r_frame_start <= 1'b0;
                        r_done_tick   <= ((r_cnt + c_CNT_W'(1)) == c_LAST);
                    end
                end
                default: begin
                    r_state       <= c_ST_IDLE;
                    r_cnt         <= '0;
                    r_frame_start <= 1'b0;
                    r_done_tick   <= 1'b0;
                end
            endcase
        end
    end

    assign sout_valid  = (r_state == c_ST_SHIFT);
    assign busy        = (r_state == c_ST_SHIFT);
    assign frame_start = r_frame_start;
    assign done_tick   = r_done_tick;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench for piso_serializer. Two instances share
//               the stimulus: one LSB-first, one MSB-first. Each cycle's
//               outputs are compared with a word-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int DW = 8;
`ifdef PISO_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din;
    logic          din_valid;

    logic sout_l, sv_l, fs_l, dt_l, busy_l, rdy_l;
    logic sout_m, sv_m, fs_m, dt_m, busy_m, rdy_m;

    always #5 clk = ~clk;

    piso_serializer #(.DATA_WIDTH(DW), .LSB_FIRST(1)) u_dut_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .sout(sout_l), .sout_valid(sv_l),
        .frame_start(fs_l), .done_tick(dt_l), .busy(busy_l)
    );

    piso_serializer #(.DATA_WIDTH(DW), .LSB_FIRST(0)) u_dut_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .sout(sout_m), .sout_valid(sv_m),
        .frame_start(fs_m), .done_tick(dt_m), .busy(busy_m)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] words [8];
    int            nwords;
    logic [11:0]   cap [64];

    // Vector layout: {sv,fs,dt,busy,rdy,sout} of LSB dut, then same for MSB dut
    function automatic logic [11:0] obs_vec();
        return {sv_l, fs_l, dt_l, busy_l, rdy_l, sout_l,
                sv_m, fs_m, dt_m, busy_m, rdy_m, sout_m};
    endfunction

    // k-th transmitted bit of a word: data bits in the chosen order, then parity
    function automatic logic bit_of(input logic [DW-1:0] w, input int k, input bit lsb);
        if (k >= DW) return ^w;
        return lsb ? w[k] : w[DW-1-k];
    endfunction

    // Expected outputs in cycle c after the first accept (words back-to-back)
    function automatic logic [11:0] model_vec(input int c, input int abort_c);
        int t, i, k;
        logic [4:0] ctrl;
        t = c - 1;
        i = t / NB;
        k = t % NB;
        if (c < 1 || i >= nwords || (abort_c > 0 && c > abort_c)) begin
            return {5'b00001, 1'b0, 5'b00001, 1'b0};
        end
        ctrl = {1'b1, (k == 0), (k == NB - 1), 1'b1, (k == NB - 1)};
        return {ctrl, bit_of(words[i], k, 1'b1), ctrl, bit_of(words[i], k, 1'b0)};
    endfunction

    // Sends words[0..nwords-1] and records outputs; din scrambles after accepts
    task automatic run_stream(input bit hold, input int inj_c,
                              input logic [DW-1:0] inj_w, input int abort_c);
        @(negedge clk);
        din       = words[0];
        din_valid = 1'b1;
        for (int c = 1; c <= nwords * NB + 2; c++) begin
            @(negedge clk);
            cap[c]    = obs_vec();
            reset     = (c == abort_c);
            din_valid = 1'b0;
            din       = DW'($urandom);
            if (c == inj_c) begin
                din       = inj_w;
                din_valid = 1'b1;
            end
            if (hold && (c % NB == 0) && (c / NB < nwords)) begin
                din       = words[c / NB];
                din_valid = 1'b1;
            end
        end
        reset     = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] idle_v;
        idle_v    = {5'b00001, 1'b0, 5'b00001, 1'b0};
        reset     = 1'b1;
        din_valid = 1'b1;
        din       = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== idle_v) begin
                errors++;
                $display("FAIL reset_state cyc %0d got %b want %b", i, obs_vec(), idle_v);
            end
        end
        reset     = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_vec() !== idle_v) begin
            errors++;
            $display("FAIL reset_wins_over_valid got %b want %b", obs_vec(), idle_v);
        end
    endtask

    task automatic test_lsb_a5();
        logic [7:0] seq;
        seq      = 8'b10100101;
        nwords   = 1;
        words[0] = 8'hA5;
        run_stream(1'b0, 0, '0, 0);
        for (int c = 1; c <= NB + 2; c++) begin
            checks++;
            if (cap[c] !== model_vec(c, 0)) begin
                errors++;
                $display("FAIL a5_stream cyc %0d got %b want %b", c, cap[c], model_vec(c, 0));
            end
        end
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (cap[c][6] !== seq[8-c]) begin
                errors++;
                $display("FAIL a5_lsb_bit cyc %0d got %b want %b", c, cap[c][6], seq[8-c]);
            end
        end
    endtask

    task automatic test_msb_81();
        logic [7:0] seq;
        seq      = 8'b10000001;
        nwords   = 1;
        words[0] = 8'h81;
        run_stream(1'b0, 0, '0, 0);
        for (int c = 1; c <= NB + 2; c++) begin
            checks++;
            if (cap[c] !== model_vec(c, 0)) begin
                errors++;
                $display("FAIL x81_stream cyc %0d got %b want %b", c, cap[c], model_vec(c, 0));
            end
        end
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (cap[c][0] !== seq[8-c]) begin
                errors++;
                $display("FAIL x81_msb_bit cyc %0d got %b want %b", c, cap[c][0], seq[8-c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        nwords   = 2;
        words[0] = 8'hFF;
        words[1] = 8'h00;
        run_stream(1'b1, 0, '0, 0);
        for (int c = 1; c <= 2 * NB + 2; c++) begin
            checks++;
            if (cap[c] !== model_vec(c, 0)) begin
                errors++;
                $display("FAIL b2b cyc %0d got %b want %b", c, cap[c], model_vec(c, 0));
            end
        end
    endtask

    task automatic test_ignore_midword();
        nwords   = 1;
        words[0] = 8'hA5;
        run_stream(1'b0, 4, 8'h3C, 0);
        for (int c = 1; c <= NB + 2; c++) begin
            checks++;
            if (cap[c] !== model_vec(c, 0)) begin
                errors++;
                $display("FAIL ignore_valid cyc %0d got %b want %b", c, cap[c], model_vec(c, 0));
            end
        end
    endtask

    task automatic test_abort();
        nwords   = 1;
        words[0] = 8'hA5;
        run_stream(1'b0, 0, '0, 5);
        for (int c = 1; c <= NB + 2; c++) begin
            checks++;
            if (cap[c] !== model_vec(c, 5)) begin
                errors++;
                $display("FAIL abort cyc %0d got %b want %b", c, cap[c], model_vec(c, 5));
            end
        end
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        logic [7:0] pw [2];
        logic       pb [2];
        pw[0] = 8'h07; pb[0] = 1'b1;
        pw[1] = 8'h03; pb[1] = 1'b0;
        for (int j = 0; j < 2; j++) begin
            nwords   = 1;
            words[0] = pw[j];
            run_stream(1'b0, 0, '0, 0);
            checks++;
            if (cap[9][6] !== pb[j] || cap[9][0] !== pb[j] || cap[9][9] !== 1'b1) begin
                errors++;
                $display("FAIL parity_bit word %h got sout %b/%b dt %b want %b dt 1",
                         pw[j], cap[9][6], cap[9][0], cap[9][9], pb[j]);
            end
            for (int c = 1; c <= NB + 2; c++) begin
                checks++;
                if (cap[c] !== model_vec(c, 0)) begin
                    errors++;
                    $display("FAIL parity_stream cyc %0d got %b want %b", c, cap[c], model_vec(c, 0));
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        bit hold;
        for (int it = 0; it < 20; it++) begin
            nwords = int'($urandom_range(1, 4));
            for (int i = 0; i < nwords; i++) begin
                words[i] = DW'($urandom);
            end
            hold = (nwords > 1) ? 1'b1 : 1'($urandom_range(0, 1));
            run_stream(hold, 0, '0, 0);
            for (int c = 1; c <= nwords * NB + 2; c++) begin
                checks++;
                if (cap[c] !== model_vec(c, 0)) begin
                    errors++;
                    $display("FAIL random it %0d cyc %0d got %b want %b",
                             it, c, cap[c], model_vec(c, 0));
                end
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        nwords    = 0;
        test_reset();
        test_lsb_a5();
        test_msb_81();
        test_back_to_back();
        test_ignore_midword();
        test_abort();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
